// File: rtl/line_draw_pkg.sv
// Shared definitions for the line-draw scheduler.
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - default coordinate width
//   - line_cmd_t plus a packing helper for building commands at the default width
package line_draw_pkg;

   localparam int unsigned DefCw = 10;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StLaunch = 2'd1;
   localparam logic [1:0] StDraw   = 2'd2;
   localparam logic [1:0] StAck    = 2'd3;

   typedef struct packed {
      logic [DefCw-1:0] x0;
      logic [DefCw-1:0] y0;
      logic [DefCw-1:0] x1;
      logic [DefCw-1:0] y1;
   } line_cmd_t;

   function automatic line_cmd_t pack_line(input logic [DefCw-1:0] x0,
                                           input logic [DefCw-1:0] y0,
                                           input logic [DefCw-1:0] x1,
                                           input logic [DefCw-1:0] y1);
      line_cmd_t c;
      c.x0 = x0;
      c.y0 = y0;
      c.x1 = x1;
      c.y1 = y1;
      return c;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  highest-priority index this round
//   valid out 1   any request set
//   idx   out IW  first set request searching ptr, ptr+1, ... modulo N
module rr_pick #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [IW:0]    sum;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      // Rotate so bit 0 is the ptr position; lowest set bit wins.
      dbl   = {req, req} >> ptr;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (dbl[i]) begin
            valid = 1'b1;
            sum   = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
               sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/line_draw_sched.sv
// Round-robin scheduler sharing one Bresenham line engine between N_REQ requesters.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req, req_x0/y0/x1/y1            per-requester command valid and packed endpoints
//   ack, ack_err                    one-hot retire pulse, qualified by timeout flag
//   eng_start, eng_abort            single-cycle launch / abort pulses to the engine
//   eng_x0/y0/x1/y1                 latched command, stable from eng_start until ack
//   eng_done                        engine completion pulse
//   busy, active_id                 scheduler occupied, granted requester index
module line_draw_sched
   import line_draw_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned CW      = DefCw,
   parameter int unsigned TIMEOUT = 4096,
   parameter int unsigned TW      = 13,
   localparam int unsigned IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*CW-1:0] req_x0,
   input  logic [N_REQ*CW-1:0] req_y0,
   input  logic [N_REQ*CW-1:0] req_x1,
   input  logic [N_REQ*CW-1:0] req_y1,
   output logic [N_REQ-1:0]    ack,
   output logic                ack_err,
   output logic                eng_start,
   output logic                eng_abort,
   output logic [CW-1:0]       eng_x0,
   output logic [CW-1:0]       eng_y0,
   output logic [CW-1:0]       eng_x1,
   output logic [CW-1:0]       eng_y1,
   input  logic                eng_done,
   output logic                busy,
   output logic [IW-1:0]       active_id
);

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] active_id_q, active_id_d;
   logic [CW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
   logic [TW-1:0] wd_q, wd_d;
   logic          err_q, err_d;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          expire;

   rr_pick #(
      .N(N_REQ)
   ) u_rr_pick (
      .req  (req),
      .ptr  (rr_ptr_q),
      .valid(pick_valid),
      .idx  (pick_idx)
   );

   assign expire = (wd_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      active_id_d = active_id_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      x1_d        = x1_q;
      y1_d        = y1_q;
      wd_d        = wd_q;
      err_d       = err_q;
      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               active_id_d = pick_idx;
               // Constant part-selects, muxed by the winning index.
               for (int i = 0; i < int'(N_REQ); i++) begin
                  if (pick_idx == IW'(i)) begin
                     x0_d = req_x0[i*CW +: CW];
                     y0_d = req_y0[i*CW +: CW];
                     x1_d = req_x1[i*CW +: CW];
                     y1_d = req_y1[i*CW +: CW];
                  end
               end
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            wd_d    = '0;
            state_d = StDraw;
         end
         StDraw: begin
            wd_d = wd_q + 1'b1;
            // done takes priority over a simultaneous watchdog expiry
            if (eng_done) begin
               err_d   = 1'b0;
               state_d = StAck;
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = StAck;
            end
         end
         StAck: begin
            rr_ptr_d = (active_id_q == IW'(N_REQ - 1)) ? '0 : active_id_q + 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         active_id_q <= '0;
         x0_q        <= '0;
         y0_q        <= '0;
         x1_q        <= '0;
         y1_q        <= '0;
         wd_q        <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         active_id_q <= active_id_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         wd_q        <= wd_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      ack = '0;
      if (state_q == StAck) begin
         ack[active_id_q] = 1'b1;
      end
   end

   assign ack_err   = (state_q == StAck) && err_q;
   assign eng_start = (state_q == StLaunch);
   assign eng_abort = (state_q == StDraw) && !eng_done && expire;
   assign busy      = (state_q != StIdle);
   assign active_id = active_id_q;
   assign eng_x0    = x0_q;
   assign eng_y0    = y0_q;
   assign eng_x1    = x1_q;
   assign eng_y1    = y1_q;

endmodule

// File: tb/tb_line_draw_sched.sv
// Self-checking bench for line_draw_sched: scoreboard of expected grants/acks,
// behavioural engine that answers each start after a per-command delay.
module tb_line_draw_sched;
   import line_draw_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = DefCw;
   localparam int unsigned TO = 64;
   localparam int unsigned TW = 7;
   localparam int          IW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N*CW-1:0]   req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
   logic              eng_done = 1'b0;
   logic [N-1:0]      ack;
   logic              ack_err, eng_start, eng_abort, busy;
   logic [CW-1:0]     eng_x0, eng_y0, eng_x1, eng_y1;
   logic [IW-1:0]     active_id;

   line_draw_sched #(
      .N_REQ(N), .CW(CW), .TIMEOUT(TO), .TW(TW)
   ) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
      .ack(ack), .ack_err(ack_err), .eng_start(eng_start), .eng_abort(eng_abort),
      .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
      .eng_done(eng_done), .busy(busy), .active_id(active_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int        id;
      line_cmd_t cmd;
      int        delay;  // cycles from start to done; negative = never done
      bit        err;
   } exp_t;

   exp_t q_start[$];
   exp_t q_ack[$];
   exp_t mon_e;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, start_cyc = 0, done_cyc = 0, req_cyc = 0;
   int ack_cnt = 0, start_cnt = 0;
   bit eng_pending = 0, abort_seen = 0, gap_check = 0, last_valid = 0, lat_check = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor / scoreboard, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            q_ack.delete();
            eng_pending = 0;
            abort_seen  = 0;
         end else begin
            if (eng_start) begin
               if (q_start.size() == 0) begin
                  check("unexpected_start", 64'(eng_start), 64'(0));
               end else begin
                  mon_e = q_start.pop_front();
                  check("grant_id", 64'(active_id), 64'(mon_e.id));
                  check("start_x0", 64'(eng_x0), 64'(mon_e.cmd.x0));
                  check("start_y0", 64'(eng_y0), 64'(mon_e.cmd.y0));
                  check("start_x1", 64'(eng_x1), 64'(mon_e.cmd.x1));
                  check("start_y1", 64'(eng_y1), 64'(mon_e.cmd.y1));
                  if (gap_check && last_valid) check("start_gap", 64'(cyc - start_cyc), 64'(13));
                  if (lat_check) begin
                     check("start_latency", 64'(cyc - req_cyc), 64'(1));
                     lat_check = 0;
                  end
                  last_valid = 1;
                  start_cyc  = cyc;
                  if (mon_e.delay >= 0) begin
                     eng_pending = 1;
                     done_cyc    = cyc + mon_e.delay;
                  end
                  q_ack.push_back(mon_e);
                  start_cnt++;
               end
            end
            if (eng_abort) begin
               abort_seen = 1;
               eng_pending = 0;
               check("abort_cycle", 64'(cyc - start_cyc), 64'(TO));
            end
            if (ack != '0) begin
               if (q_ack.size() == 0) begin
                  check("unexpected_ack", 64'(ack), 64'(0));
               end else begin
                  mon_e = q_ack.pop_front();
                  check("ack_onehot", 64'(ack), 64'(1) << mon_e.id);
                  check("ack_err", 64'(ack_err), 64'(mon_e.err));
                  check("abort_iff_err", 64'(abort_seen), 64'(mon_e.err));
                  check("hold_x0", 64'(eng_x0), 64'(mon_e.cmd.x0));
                  check("hold_y1", 64'(eng_y1), 64'(mon_e.cmd.y1));
               end
               abort_seen = 0;
               ack_cnt++;
            end
         end
      end
   end

   // Behavioural engine: raise eng_done for one cycle at the scheduled cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         eng_done = eng_pending && !rst && (cyc + 1 == done_cyc);
         if (eng_done) eng_pending = 0;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_cmd(input int id, input line_cmd_t c);
      req_x0[id*CW +: CW] = c.x0;
      req_y0[id*CW +: CW] = c.y0;
      req_x1[id*CW +: CW] = c.x1;
      req_y1[id*CW +: CW] = c.y1;
   endtask

   task automatic expect_cmd(input int id, input line_cmd_t c, input int delay, input bit err);
      exp_t e;
      e.id = id; e.cmd = c; e.delay = delay; e.err = err;
      q_start.push_back(e);
   endtask

   task automatic wait_acks(input int target, input int budget);
      int k = 0;
      while (ack_cnt < target && k < budget) begin
         step();
         k++;
      end
      check("acks_reached", 64'(ack_cnt), 64'(target));
   endtask

   task automatic wait_starts(input int target, input int budget);
      int k = 0;
      while (start_cnt < target && k < budget) begin
         step();
         k++;
      end
      check("starts_reached", 64'(start_cnt), 64'(target));
   endtask

   line_cmd_t c;

   initial begin
      // Reset state
      step(3);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ack", 64'({ack, ack_err}), 64'(0));
      check("rst_pulses", 64'({eng_start, eng_abort}), 64'(0));
      check("rst_coords", 64'({eng_x0, eng_y0, eng_x1, eng_y1}), 64'(0));
      check("rst_active_id", 64'(active_id), 64'(0));
      rst = 1'b0;
      step();

      // Single request, done 50 cycles after start
      c = pack_line(10'd1, 10'd2, 10'd40, 10'd30);
      set_cmd(0, c);
      expect_cmd(0, c, 50, 1'b0);
      req_cyc   = cyc;
      lat_check = 1;
      req       = 4'b0001;
      wait_acks(ack_cnt + 1, 200);
      req = '0;
      step(2);

      // Fairness from reset, all requesters active
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_cmd(i, pack_line(10'(10*i + 3), 10'(20*i + 5), 10'(639 - i), 10'(479 - i)));
      end
      for (int k = 0; k < 5; k++) begin
         c = pack_line(10'(10*(k%4) + 3), 10'(20*(k%4) + 5), 10'(639 - k%4), 10'(479 - k%4));
         expect_cmd(k % 4, c, 10, 1'b0);
      end
      last_valid = 0;
      gap_check  = 1;
      req        = 4'b1111;
      wait_acks(ack_cnt + 5, 400);
      req       = '0;
      gap_check = 0;
      step(2);

      // Timeout on requester 1, then pending requester 2 served
      c = pack_line(10'd5, 10'd6, 10'd7, 10'd8);
      set_cmd(1, c);
      expect_cmd(1, c, -1, 1'b1);
      c = pack_line(10'd600, 10'd400, 10'd0, 10'd0);
      set_cmd(2, c);
      expect_cmd(2, c, 5, 1'b0);
      req = 4'b0110;
      wait_acks(ack_cnt + 1, TO + 20);
      req[1] = 1'b0;
      wait_acks(ack_cnt + 1, 50);
      req = '0;
      step(2);

      // Done on the exact expiry cycle, degenerate line
      c = pack_line(10'd7, 10'd7, 10'd7, 10'd7);
      set_cmd(3, c);
      expect_cmd(3, c, TO, 1'b0);
      req = 4'b1000;
      wait_acks(ack_cnt + 1, TO + 20);
      req = '0;
      step(2);

      // Coordinates change and req drops mid-draw
      c = pack_line(10'd100, 10'd200, 10'd300, 10'd400);
      set_cmd(0, c);
      expect_cmd(0, c, 20, 1'b0);
      req = 4'b0001;
      wait_starts(start_cnt + 1, 10);
      step(3);
      req_x0[0 +: CW] = 10'd555;
      req[0]          = 1'b0;
      wait_acks(ack_cnt + 1, 40);
      step(2);

      // Reset mid-draw
      c = pack_line(10'd11, 10'd22, 10'd33, 10'd44);
      set_cmd(3, c);
      expect_cmd(3, c, 30, 1'b0);
      req = 4'b1000;
      wait_starts(start_cnt + 1, 10);
      step(5);
      req = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_start", 64'(eng_start), 64'(0));
      check("midrst_ack", 64'(ack), 64'(0));
      step(40);
      // rr_ptr back at 0: requester 0 wins over 2, then 2 is served
      c = pack_line(10'd50, 10'd60, 10'd70, 10'd80);
      set_cmd(0, c);
      expect_cmd(0, c, 4, 1'b0);
      c = pack_line(10'd90, 10'd91, 10'd92, 10'd93);
      set_cmd(2, c);
      expect_cmd(2, c, 4, 1'b0);
      req = 4'b0101;
      wait_acks(ack_cnt + 1, 30);
      req[0] = 1'b0;
      wait_acks(ack_cnt + 1, 30);
      req = '0;
      step(5);

      check("scoreboard_empty", 64'(q_start.size() + q_ack.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
